// File: rtl/cpu_init_seq_pkg.sv
// Shared types and defaults for the post-reset init sequencer.
// Build option: CPU_INIT_SCRUB_EN adds the cache/TLB scrub walk.
package cpu_init_seq_pkg;

    localparam int DEF_NTHREAD   = 64;
    localparam int DEF_NLINE     = 256;
    localparam int DEF_START_DLY = 4;
    localparam int DLY_W         = 4;

    // Width of an index for n entries; never narrower than one bit.
    function automatic int log2x(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int TID_W = log2x(DEF_NTHREAD);

    typedef logic [TID_W-1:0] thread_id_t;
    typedef logic [2:0]       init_state_t;

    localparam init_state_t ST_IDLE   = 3'd0;
    localparam init_state_t ST_WAIT   = 3'd1;
    localparam init_state_t ST_THREAD = 3'd2;
    localparam init_state_t ST_SCRUB  = 3'd3;
    localparam init_state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/cpu_init_seq_walk_cnt.sv
// Clearable, enabled up-counter with an all-ones terminal flag.
// Used for the thread-ID walk and the scrub line walk.
module init_walk_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);

    // Clear wins over enable; caller gates enable at terminal count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = &cnt;

endmodule

// File: rtl/cpu_init_seq.sv
// Post-reset sequencer: walks all thread IDs with one init beat each.
// Build option: CPU_INIT_SCRUB_EN appends an NLINE-beat scrub walk.
module cpu_init_seq
    import cpu_init_seq_pkg::*;
#(
    parameter int NTHREAD   = DEF_NTHREAD,
    parameter int NLINE     = DEF_NLINE,
    parameter int START_DLY = DEF_START_DLY
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cpu_rst,
    input  logic                      init_ready,
    output logic                      init_valid,
    output logic [log2x(NTHREAD)-1:0] init_tid,
    output logic [log2x(NLINE)-1:0]   init_line,
    output logic                      init_scrub,
    output logic [NTHREAD-1:0]        thread_en,
    output logic                      busy,
    output logic                      done
);

    localparam int TW = log2x(NTHREAD);
    localparam int LW = log2x(NLINE);

    init_state_t      state;
    init_state_t      state_nxt;
    logic [DLY_W-1:0] dly_cnt;
    logic             dly_last;

    logic             st_idle;
    logic             st_wait;
    logic             st_thread;
    logic             st_scrub;
    logic             st_done;

    logic [TW-1:0]    tid;
    logic             tid_last;
    logic             acc_t;

    assign st_idle   = (state == ST_IDLE);
    assign st_wait   = (state == ST_WAIT);
    assign st_thread = (state == ST_THREAD);
    assign st_done   = (state == ST_DONE);

    assign dly_last  = (dly_cnt == DLY_W'(START_DLY - 1));
    assign acc_t     = st_thread & init_ready;

    init_walk_cnt #(.W(TW)) u_tid_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cpu_rst | ~st_thread),
        .en   (acc_t & ~tid_last),
        .cnt  (tid),
        .last (tid_last)
    );

`ifdef CPU_INIT_SCRUB_EN
    logic [LW-1:0] line;
    logic          line_last;
    logic          acc_s;

    assign st_scrub = (state == ST_SCRUB);
    assign acc_s    = st_scrub & init_ready;

    init_walk_cnt #(.W(LW)) u_line_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cpu_rst | ~st_scrub),
        .en   (acc_s & ~line_last),
        .cnt  (line),
        .last (line_last)
    );

    assign init_line  = st_scrub ? line : '0;
    assign init_scrub = st_scrub;
`else
    assign st_scrub   = 1'b0;
    assign init_line  = '0;
    assign init_scrub = 1'b0;
`endif

    // Sequencer state; cpu_rst pulls back to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (cpu_rst) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (1'b1)
                st_idle: state_nxt = ST_WAIT;
                st_wait: begin
                    if (dly_last) state_nxt = ST_THREAD;
                end
                st_thread: begin
                    if (acc_t && tid_last) begin
`ifdef CPU_INIT_SCRUB_EN
                        state_nxt = ST_SCRUB;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
`ifdef CPU_INIT_SCRUB_EN
                st_scrub: begin
                    if (acc_s && line_last) state_nxt = ST_DONE;
                end
`endif
                st_done: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start delay counter; only runs while waiting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly_cnt <= '0;
        end else if (cpu_rst || !st_wait) begin
            dly_cnt <= '0;
        end else begin
            dly_cnt <= dly_cnt + 1'b1;
        end
    end

    // Release each thread once its init beat is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            thread_en <= '0;
        end else if (cpu_rst) begin
            thread_en <= '0;
        end else if (acc_t) begin
            thread_en[tid] <= 1'b1;
        end
    end

    assign init_valid = st_thread | st_scrub;
    assign init_tid   = st_thread ? tid : '0;
    assign busy       = st_wait | st_thread | st_scrub;
    assign done       = st_done;

endmodule
